// File: rtl/memory_responder.sv
// memory_responder
// Word-addressed synchronous RAM that serves datapath memory requests.
// A request is accepted in IDLE. The access completes after WAIT_CYCLES
// busy cycles, and done is pulsed for one cycle.
//
// Ports:
//   clk       rising-edge clock (only clock)
//   clr       synchronous active-high reset
//   read      read request, level, sampled only in IDLE
//   write     write request, level, sampled only in IDLE (wins over read)
//   address   word address (MAR low bits)
//   data_in   write data (from MDR)
//   data_out  registered read data (to MDR memory-side input)
//   done      one-cycle completion strobe
//   busy      high while a transaction is in progress (BUSY or DONE)
module memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] waitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                  stateReg, stateNext;
  logic [3:0]             countReg, countNext;
  logic                   opWriteReg, opWriteNext;
  logic [ADDR_WIDTH-1:0]  addrReg, addrNext;
  logic [DATA_WIDTH-1:0]  dataReg, dataNext;

  // Operands used on the commit edge. With WAIT_CYCLES = 0 the commit
  // happens on the acceptance edge itself, so the live inputs must be used
  // because the latches are not loaded yet.
  logic                   commitWrite;
  logic [ADDR_WIDTH-1:0]  commitAddr;
  logic [DATA_WIDTH-1:0]  commitData;
  logic                   commit;
  logic                   memWe;
  logic                   memRe;

  logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]  dataOutReg;

  always_comb begin
    stateNext   = stateReg;
    countNext   = countReg;
    opWriteNext = opWriteReg;
    addrNext    = addrReg;
    dataNext    = dataReg;
    commitWrite = opWriteReg;
    commitAddr  = addrReg;
    commitData  = dataReg;

    case (stateReg)
      IDLE: begin
        if (read || write) begin
          // Write has priority: a simultaneous read is dropped.
          opWriteNext = write;
          addrNext    = address;
          dataNext    = data_in;
          countNext   = waitLoad;
          commitWrite = write;
          commitAddr  = address;
          commitData  = data_in;
          stateNext   = (waitLoad != 4'd0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        countNext = countReg - 4'd1;
        if (countReg == 4'd1) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // DONE always exits to IDLE, so stateNext == DONE only on the entering edge.
    commit = (stateNext == DONE) && (stateReg != DONE);
    // A reset on the commit edge wins, so the access is suppressed.
    memWe  = commit && commitWrite && !clr;
    memRe  = commit && !commitWrite && !clr;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stateReg   <= IDLE;
      countReg   <= 4'd0;
      opWriteReg <= 1'b0;
      addrReg    <= '0;
      dataReg    <= '0;
    end else begin
      stateReg   <= stateNext;
      countReg   <= countNext;
      opWriteReg <= opWriteNext;
      addrReg    <= addrNext;
      dataReg    <= dataNext;
    end
  end

  // Storage array. The contents are not affected by clr.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[commitAddr] <= commitData;
    end
  end

  // Registered read port. The value is held until the next read commit.
  always_ff @(posedge clk) begin
    if (clr) begin
      dataOutReg <= '0;
    end else if (memRe) begin
      dataOutReg <= mem[commitAddr];
    end
  end

  assign data_out = dataOutReg;
  assign done     = (stateReg == DONE);
  assign busy     = (stateReg != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Self-checking bench for memory_responder. The bench uses two instances:
// dut runs with WAIT_CYCLES = 2 and dut0 runs with WAIT_CYCLES = 0.
// Expected read data comes from bench-side memory models. The expected
// value is queued when a read is driven and popped when done is observed.
module tb_memory_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        read, write;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done, busy;

  logic        read0, write0;
  logic [8:0]  address0;
  logic [31:0] data_in0;
  logic [31:0] data_out0;
  logic        done0, busy0;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] model  [512];
  logic [31:0] model0 [512];
  logic [31:0] expQ [$];
  logic [31:0] lastRead;
  logic [31:0] lastRead0;

  memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .done(done), .busy(busy)
  );

  memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clr(clr), .read(read0), .write(write0), .address(address0),
    .data_in(data_in0), .data_out(data_out0), .done(done0), .busy(busy0)
  );

  // Drive one request and wait (bounded) for done.
  // lat is the number of negedges from acceptance to done, or -1 on timeout.
  task automatic run_txn(input bit sel, input logic wr, input logic rd,
                         input logic [8:0] a, input logic [31:0] d,
                         input logic [8:0] aBusy,
                         output int lat, output logic [31:0] dout,
                         output bit busyOk);
    @(negedge clk);
    if (sel) begin
      write0 = wr; read0 = rd; address0 = a; data_in0 = d;
    end else begin
      write = wr; read = rd; address = a; data_in = d;
    end
    @(posedge clk);
    #1;
    if (sel) begin
      write0 = 1'b0; read0 = 1'b0; address0 = aBusy; data_in0 = ~d;
    end else begin
      write = 1'b0; read = 1'b0; address = aBusy; data_in = ~d;
    end
    lat = -1;
    dout = 'x;
    busyOk = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((sel ? busy0 : busy) !== 1'b1) busyOk = 1'b0;
      if ((sel ? done0 : done) === 1'b1) begin
        lat = i;
        dout = sel ? data_out0 : data_out;
        break;
      end
    end
    $display("[TB] txn sel=%0d wr=%0d rd=%0d addr=0x%03h data=0x%08h lat=%0d dout=0x%08h",
             sel, wr, rd, a, d, lat, dout);
  endtask

  task automatic test_reset();
    clr = 1'b1; read = 1'b1; write = 1'b0; address = 9'h0; data_in = 32'h0;
    read0 = 1'b1; write0 = 1'b0; address0 = 9'h0; data_in0 = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      testsRun++;
      if ({data_out, done, busy} !== 34'h0) begin
        testsFailed++;
        $display("FAIL reset_outputs cycle %0d: got data_out=0x%08h done=%b busy=%b, expected 0/0/0",
                 c, data_out, done, busy);
      end
      testsRun++;
      if ({data_out0, done0, busy0} !== 34'h0) begin
        testsFailed++;
        $display("FAIL reset_outputs_w0 cycle %0d: got data_out=0x%08h done=%b busy=%b, expected 0/0/0",
                 c, data_out0, done0, busy0);
      end
    end
    clr = 1'b0; read = 1'b0; read0 = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_idle: got busy=%b, expected 0", busy);
    end
    lastRead = 32'h0;
    lastRead0 = 32'h0;
    $display("[TB] reset done");
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] dout; bit busyOk; logic [31:0] exp;
    run_txn(1'b0, 1'b1, 1'b0, 9'h005, 32'hDEADBEEF, 9'h005, lat, dout, busyOk);
    model[9'h005] = 32'hDEADBEEF;
    testsRun++;
    if (lat !== 3) begin
      testsFailed++;
      $display("FAIL write_latency: got %0d, expected 3", lat);
    end
    testsRun++;
    if (busyOk !== 1'b1 || dout !== lastRead) begin
      testsFailed++;
      $display("FAIL write_busy_dout: got busyOk=%b dout=0x%08h, expected 1 and 0x%08h",
               busyOk, dout, lastRead);
    end
    expQ.push_back(model[9'h005]);
    run_txn(1'b0, 1'b0, 1'b1, 9'h005, 32'h0, 9'h005, lat, dout, busyOk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
    testsRun++;
    if (lat !== 3 || dout !== exp) begin
      testsFailed++;
      $display("FAIL read_after_write: got lat=%0d dout=0x%08h, expected 3 and 0x%08h", lat, dout, exp);
    end
    lastRead = exp;
  endtask

  task automatic test_simultaneous();
    int lat; logic [31:0] dout; bit busyOk; logic [31:0] exp;
    // Both requests high, and the address changes during BUSY.
    run_txn(1'b0, 1'b1, 1'b1, 9'h010, 32'h12345678, 9'h011, lat, dout, busyOk);
    model[9'h010] = 32'h12345678;
    testsRun++;
    if (lat !== 3 || dout !== lastRead) begin
      testsFailed++;
      $display("FAIL simultaneous_wr: got lat=%0d dout=0x%08h, expected 3 and 0x%08h", lat, dout, lastRead);
    end
    expQ.push_back(model[9'h010]);
    run_txn(1'b0, 1'b0, 1'b1, 9'h010, 32'h0, 9'h010, lat, dout, busyOk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
    testsRun++;
    if (lat !== 3 || dout !== exp) begin
      testsFailed++;
      $display("FAIL read_0x10: got lat=%0d dout=0x%08h, expected 3 and 0x%08h", lat, dout, exp);
    end
    expQ.push_back(model[9'h011]);
    run_txn(1'b0, 1'b0, 1'b1, 9'h011, 32'h0, 9'h011, lat, dout, busyOk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
    testsRun++;
    if (lat !== 3 || dout !== exp) begin
      testsFailed++;
      $display("FAIL read_0x11_untouched: got lat=%0d dout=0x%08h, expected 3 and 0x%08h", lat, dout, exp);
    end
    lastRead = exp;
  endtask

  task automatic test_back_to_back();
    int doneAt [$]; logic [31:0] exp;
    expQ.push_back(model[9'h005]);
    expQ.push_back(model[9'h005]);
    @(negedge clk);
    read = 1'b1; write = 1'b0; address = 9'h005;
    for (int c = 1; c <= 30 && doneAt.size() < 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        doneAt.push_back(c);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
        $display("[TB] held read done at cycle %0d data_out=0x%08h", c, data_out);
        testsRun++;
        if (data_out !== exp) begin
          testsFailed++;
          $display("FAIL held_read_data: got 0x%08h, expected 0x%08h", data_out, exp);
        end
        if (doneAt.size() == 2) read = 1'b0;
      end
    end
    read = 1'b0;
    testsRun++;
    if (doneAt.size() != 2) begin
      testsFailed++;
      $display("FAIL held_done_count: got %0d pulses, expected 2", doneAt.size());
    end else if (doneAt[0] != 3 || doneAt[1] - doneAt[0] != 4) begin
      testsFailed++;
      $display("FAIL held_done_spacing: got first=%0d gap=%0d, expected 3 and 4",
               doneAt[0], doneAt[1] - doneAt[0]);
    end
    repeat (2) begin
      @(negedge clk);
      testsRun++;
      if (busy !== 1'b0) begin
        testsFailed++;
        $display("FAIL held_no_third: got busy=%b, expected 0", busy);
      end
    end
    lastRead = model[9'h005];
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] dout; bit busyOk; logic [31:0] exp; bit sawDone;
    @(negedge clk);
    write = 1'b1; read = 1'b0; address = 9'h1FF; data_in = 32'hCAFEF00D;
    @(posedge clk);
    #1 write = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("FAIL abort_busy_before: got busy=%b, expected 1", busy);
    end
    clr = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({data_out, done, busy} !== 34'h0) begin
      testsFailed++;
      $display("FAIL abort_reset_state: got data_out=0x%08h done=%b busy=%b, expected 0/0/0",
               data_out, done, busy);
    end
    clr = 1'b0;
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0) begin
      testsFailed++;
      $display("FAIL abort_no_done: got done pulse, expected none");
    end
    lastRead = 32'h0;
    lastRead0 = 32'h0;
    expQ.push_back(model[9'h1FF]);
    run_txn(1'b0, 1'b0, 1'b1, 9'h1FF, 32'h0, 9'h1FF, lat, dout, busyOk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
    testsRun++;
    if (lat !== 3 || dout !== exp) begin
      testsFailed++;
      $display("FAIL abort_no_commit: got lat=%0d dout=0x%08h, expected 3 and 0x%08h", lat, dout, exp);
    end
    lastRead = exp;
  endtask

  task automatic test_wait0();
    int lat; logic [31:0] dout; bit busyOk; logic [31:0] exp;
    run_txn(1'b1, 1'b1, 1'b0, 9'h000, 32'hA5A50FF0, 9'h000, lat, dout, busyOk);
    model0[9'h000] = 32'hA5A50FF0;
    testsRun++;
    if (lat !== 1 || busyOk !== 1'b1 || dout !== lastRead0) begin
      testsFailed++;
      $display("FAIL w0_write: got lat=%0d busyOk=%b dout=0x%08h, expected 1, 1, 0x%08h",
               lat, busyOk, dout, lastRead0);
    end
    @(negedge clk);
    testsRun++;
    if (busy0 !== 1'b0) begin
      testsFailed++;
      $display("FAIL w0_busy_one_cycle: got busy=%b, expected 0", busy0);
    end
    expQ.push_back(model0[9'h000]);
    run_txn(1'b1, 1'b0, 1'b1, 9'h000, 32'h0, 9'h000, lat, dout, busyOk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
    testsRun++;
    if (lat !== 1 || dout !== exp) begin
      testsFailed++;
      $display("FAIL w0_read_addr0: got lat=%0d dout=0x%08h, expected 1 and 0x%08h", lat, dout, exp);
    end
    lastRead0 = exp;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      model[i] = 32'h0;
      model0[i] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_wait0();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
